// File: rtl/sha_digest_uart_tx_if.sv
// ---------------------------------------------------------------------------
// sha_digest_uart_tx_if
//   Groups the byte stream from the SHA-256 core and the UART status lines
//   that the digest transmitter presents to the rest of the system.
//
//   SHA_dv_flag   : digest byte valid (SHA core -> transmitter)
//   SHA_core_out  : digest byte, MSB of H0 first (SHA core -> transmitter)
//   uart_tx_out   : 8N1 serial line, idle high (transmitter -> system)
//   tx_busy       : digest capture/transmission in progress
//   tx_done       : one-cycle pulse after the last stop bit
//   overrun       : one-cycle pulse per valid byte dropped while sending
//
//   master : the side producing digest bytes and observing status
//   slave  : the digest transmitter itself
// ---------------------------------------------------------------------------
interface sha_digest_uart_tx_if;
  logic       SHA_dv_flag;
  logic [7:0] SHA_core_out;
  logic       uart_tx_out;
  logic       tx_busy;
  logic       tx_done;
  logic       overrun;

  modport master (
    output SHA_dv_flag,
    output SHA_core_out,
    input  uart_tx_out,
    input  tx_busy,
    input  tx_done,
    input  overrun
  );

  modport slave (
    input  SHA_dv_flag,
    input  SHA_core_out,
    output uart_tx_out,
    output tx_busy,
    output tx_done,
    output overrun
  );
endinterface

// File: rtl/sha_digest_uart_tx.sv
// ---------------------------------------------------------------------------
// sha_digest_uart_tx
//   Captures one complete SHA-256 digest (DIGEST_BYTES bytes) from the hash
//   core, then streams it out as back-to-back 8N1 UART frames, LSB first.
//
//   Parameters
//     CLKS_PER_BIT : clk cycles per UART bit (2..65535)
//     DIGEST_BYTES : bytes per digest
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : slave modport of sha_digest_uart_tx_if (byte input, serial
//            output, busy/done/overrun status)
// ---------------------------------------------------------------------------
module sha_digest_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DIGEST_BYTES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sha_digest_uart_tx_if.slave   bus
);

  localparam int IDX_W  = $clog2(DIGEST_BYTES + 1);
  localparam int ADDR_W = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;

  localparam logic [IDX_W-1:0]  LAST_CAP  = IDX_W'(DIGEST_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_TX   = ADDR_W'(DIGEST_BYTES - 1);
  localparam logic [15:0]       BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  logic [7:0]        buffer_q [DIGEST_BYTES];
  state_t            state_q;
  logic [IDX_W-1:0]  capIdx_q;
  logic [ADDR_W-1:0] txIdx_q;
  logic [15:0]       baudCnt_q;
  logic [2:0]        bitIdx_q;
  logic              txLine_q;
  logic              busy_q;
  logic              done_q;
  logic              overrun_q;

  logic              captureEn_d;
  logic              bitEnd_d;
  logic [7:0]        txByte_d;

  // Bytes are accepted only while collecting a digest; once sending starts
  // any new valid byte is an overrun and must not disturb the buffer.
  // IDLE always has capIdx_q at zero, so both states share one write port.
  assign captureEn_d = bus.SHA_dv_flag && ((state_q == IDLE) || (state_q == CAPTURE));
  assign bitEnd_d    = (baudCnt_q == BAUD_LAST);
  assign txByte_d    = buffer_q[txIdx_q];

  // Digest storage. No reset: every entry is rewritten during capture
  // before the transmitter is allowed to read it.
  always_ff @(posedge clk) begin
    if (captureEn_d) begin
      buffer_q[capIdx_q[ADDR_W-1:0]] <= bus.SHA_core_out;
    end
  end

  // Capture/transmit sequencer. Every output is a flop updated on the same
  // edge as the state change it belongs to, so the serial line toggles
  // exactly when a bit period begins and never glitches. The baud counter
  // wraps on each bit boundary, which makes consecutive frames abut with
  // no idle time between the stop bit and the next start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      capIdx_q  <= '0;
      txIdx_q   <= '0;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      txLine_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        IDLE, CAPTURE: begin
          if (bus.SHA_dv_flag) begin
            capIdx_q <= capIdx_q + 1'b1;
            busy_q   <= 1'b1;
            if (capIdx_q == LAST_CAP) begin
              state_q   <= START;
              baudCnt_q <= '0;
              txIdx_q   <= '0;
              bitIdx_q  <= '0;
              txLine_q  <= 1'b0;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end

        START: begin
          overrun_q <= bus.SHA_dv_flag;
          if (bitEnd_d) begin
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            txLine_q  <= txByte_d[0];
            state_q   <= DATA;
          end else begin
            baudCnt_q <= baudCnt_q + 16'd1;
          end
        end

        DATA: begin
          overrun_q <= bus.SHA_dv_flag;
          if (bitEnd_d) begin
            baudCnt_q <= '0;
            if (bitIdx_q == 3'd7) begin
              txLine_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              txLine_q <= txByte_d[bitIdx_q + 3'd1];
            end
          end else begin
            baudCnt_q <= baudCnt_q + 16'd1;
          end
        end

        STOP: begin
          overrun_q <= bus.SHA_dv_flag;
          if (bitEnd_d) begin
            baudCnt_q <= '0;
            if (txIdx_q == LAST_TX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              txIdx_q  <= txIdx_q + 1'b1;
              txLine_q <= 1'b0;
              state_q  <= START;
            end
          end else begin
            baudCnt_q <= baudCnt_q + 16'd1;
          end
        end

        DONE: begin
          capIdx_q <= '0;
          txIdx_q  <= '0;
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.uart_tx_out = txLine_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.overrun     = overrun_q;

endmodule
